// File: rtl/inv_sub_shift_ark.sv
// AES decryption round front half: InvShiftRows at capture, then InvSubBytes and
// AddRoundKey over N = 16/BYTES_PER_CYCLE cycles through shared inverse S-box lanes.
module inv_sub_shift_ark #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int N     = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } fsm_e;

    // Element k of a block_t is byte k = 4c+r, i.e. bits [127-8k -: 8].
    typedef logic [0:15][7:0] block_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // sh(r,c) = s(r,(c-r) mod 4): row r rotates right by r columns.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t sh;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh[4*c + r] = s[4*((c - r) & 3) + r];
            end
        end
        return sh;
    endfunction

    fsm_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    block_t           sh_q, sh_d;
    block_t           key_q, key_d;
    block_t           res_q, res_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [3:0]       base;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        key_d   = key_q;
        res_d   = res_q;
        base    = 4'(int'(cnt_q) * BYTES_PER_CYCLE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = inv_shift_rows(state_in);
                    key_d   = round_key;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                    res_d[base + 4'(l)] = INV_SBOX[sh_q[base + 4'(l)]] ^ key_q[base + 4'(l)];
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered from the next state so they line up with it.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; the byte registers are small enough to reset outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            key_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            key_q       <= key_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = res_q;

endmodule

// File: tb/tb_inv_sub_shift_ark.sv
// Bench for inv_sub_shift_ark at 1, 4 and 16 lanes: fixed vectors, backpressure,
// mid-block reset and randomized traffic against a GF(2^8)-derived reference.
module tb_inv_sub_shift_ark;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] state_out [3];

    localparam int N_OF [3] = '{16, 4, 1};

    int total = 0;
    int bad   = 0;

    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    inv_sub_shift_ark #(.BYTES_PER_CYCLE(1)) u_bpc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .state_in(state_in), .round_key(round_key), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .state_out(state_out[0]), .busy(busy[0]));

    inv_sub_shift_ark #(.BYTES_PER_CYCLE(4)) u_bpc4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .state_in(state_in), .round_key(round_key), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .state_out(state_out[1]), .busy(busy[1]));

    inv_sub_shift_ark #(.BYTES_PER_CYCLE(16)) u_bpc16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .state_in(state_in), .round_key(round_key), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .state_out(state_out[2]), .busy(busy[2]));

    // Reference S-box built from field arithmetic: sbox(x) = affine(x^-1), then inverted.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] rot;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s   = inv ^ 8'h63;
        rot = inv;
        for (int i = 0; i < 4; i++) begin
            rot = {rot[6:0], rot[7]};
            s   = s ^ rot;
        end
        return s;
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] st, input logic [127:0] key);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-32*c-8*r -: 8] = inv_tab[st[127-32*((c-r)&3)-8*r -: 8]] ^ key[127-32*c-8*r -: 8];
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present one block to lane d and wait (bounded) for out_valid; lat counts edges after accept.
    task automatic run_block(input int d, input logic [127:0] st, input logic [127:0] key,
                             output logic [127:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready[d] && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        state_in    = st;
        round_key   = key;
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        res = state_out[d];
    endtask

    task automatic handshake(input int d);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic random_run(input int d, input int nblk);
        logic [127:0] q[$];
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic acc = 1'b0;
        while (recv < nblk && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                in_valid[d] = 1'b0;
                acc = 1'b0;
            end
            out_ready[d] = ($urandom_range(0, 2) != 0);
            if (out_valid[d] && out_ready[d]) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand%0d_extra: got output %h with nothing outstanding", d, state_out[d]);
                end else begin
                    check($sformatf("rand%0d_blk%0d", d, recv), state_out[d], q.pop_front());
                end
                recv++;
            end
            if (!in_valid[d]) begin
                state_in  = {$urandom, $urandom, $urandom, $urandom};
                round_key = {$urandom, $urandom, $urandom, $urandom};
                if (sent < nblk && $urandom_range(0, 2) == 0) in_valid[d] = 1'b1;
            end
            if (in_valid[d] && in_ready[d]) begin
                q.push_back(ref_block(state_in, round_key));
                sent++;
                acc = 1'b1;
            end
        end
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        check($sformatf("rand%0d_recv", d), 128'(recv), 128'(nblk));
        check($sformatf("rand%0d_sent", d), 128'(sent), 128'(nblk));
        check($sformatf("rand%0d_left", d), 128'(q.size()), 128'd0);
    endtask

    typedef struct {
        string        name;
        logic [127:0] st;
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [127:0] res;
        logic [127:0] st;
        logic [127:0] key;
        logic [127:0] held;
        int           lat;
        logic         stable;

        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

        vecs[0] = '{"sub_63",    {16{8'h63}}, 128'h0,      128'h0};
        vecs[1] = '{"sub_00",    128'h0,      128'h0,      {16{8'h52}}};
        vecs[2] = '{"key_ff",    128'h0,      {16{8'hff}}, {16{8'had}}};
        vecs[3] = '{"shift_r1",  128'h0063_0000_0000_0000_0000_0000_0000_0000, 128'h0,
                    128'h52525252_52005252_52525252_52525252};
        vecs[4] = '{"sub_ff",    {16{8'hff}}, 128'h0,      {16{8'h7d}}};
        vecs[5] = '{"sub_01",    {16{8'h01}}, 128'h0,      {16{8'h09}}};
        st  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        vecs[6] = '{"rand_vec",  st, key, ref_block(st, key)};

        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        state_in  = '0;
        round_key = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst%0d_out_valid", d), 128'(out_valid[d]), 128'd0);
            check($sformatf("rst%0d_busy", d), 128'(busy[d]), 128'd0);
            check($sformatf("rst%0d_state_out", d), state_out[d], 128'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst%0d_in_ready", d), 128'(in_ready[d]), 128'd1);
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 7; i++) begin
                run_block(d, vecs[i].st, vecs[i].key, res, lat);
                check($sformatf("%s_bpc%0d", vecs[i].name, d), res, vecs[i].exp);
                check($sformatf("%s_lat%0d", vecs[i].name, d), 128'(lat), 128'(N_OF[d]));
                handshake(d);
                check($sformatf("%s_drop%0d", vecs[i].name, d), 128'(out_valid[d]), 128'd0);
                check($sformatf("%s_rdy%0d", vecs[i].name, d), 128'(in_ready[d]), 128'd1);
            end
        end

        // Backpressure: result held for 10 cycles while a competing in_valid is ignored.
        st  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, st, key, held, lat);
        check("bp_result", held, ref_block(st, key));
        in_valid[0] = 1'b1;
        state_in    = ~st;
        stable      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state_out[0] !== held || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", 128'(stable), 128'd1);
        in_valid[0] = 1'b0;
        handshake(0);
        check("bp_hs_valid", 128'(out_valid[0]), 128'd0);
        check("bp_hs_ready", 128'(in_ready[0]), 128'd1);
        check("bp_hs_keep", state_out[0], held);
        @(negedge clk);
        check("bp_no_stale_accept", 128'(busy[0]), 128'd0);

        // Reset with the counter at 7, then a clean block.
        @(negedge clk);
        state_in    = {$urandom, $urandom, $urandom, $urandom};
        round_key   = {$urandom, $urandom, $urandom, $urandom};
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy_before", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 128'(out_valid[0]), 128'd0);
        check("mid_busy", 128'(busy[0]), 128'd0);
        check("mid_state_out", state_out[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(0, {16{8'h01}}, 128'h0, res, lat);
        check("mid_after_res", res, {16{8'h09}});
        check("mid_after_lat", 128'(lat), 128'd16);
        handshake(0);

        for (int d = 0; d < 3; d++) random_run(d, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
